// File: rtl/alpaca_ospfb_utils_pkg.sv
// Shared types and default geometry for the OSPFB output capture path.
// The bench uses the same constants to size and check its readback.
package alpaca_ospfb_utils_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SKIP,
        CAPTURE,
        FULL
    } cap_state_t;

    localparam int CAP_WIDTH       = 32;
    localparam int CAP_FFT_LEN     = 64;
    localparam int CAP_FRAMES      = 16;
    localparam int CAP_SKIP_FRAMES = 2;
    localparam int CAP_DEPTH       = CAP_FRAMES * CAP_FFT_LEN;

    // Counter width that still works for a count of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module capture_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_frame_capture.sv
// Frame-aligned AXI-Stream capture: syncs on tlast, skips pipeline-fill frames,
// then stores FRAMES whole frames for synchronous readback.
module axis_frame_capture
    import alpaca_ospfb_utils_pkg::*;
#(
    parameter int WIDTH       = CAP_WIDTH,
    parameter int FFT_LEN     = CAP_FFT_LEN,
    parameter int FRAMES      = CAP_FRAMES,
    parameter int SKIP_FRAMES = CAP_SKIP_FRAMES,
    localparam int DEPTH      = FRAMES * FFT_LEN,
    localparam int AW         = cnt_w(DEPTH),
    localparam int FCW        = cnt_w(FRAMES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             capturing,
    output logic [FCW-1:0]   frame_cnt,
    output logic             tlast_err
);

    localparam int WCW = cnt_w(FFT_LEN);
    localparam int SCW = cnt_w(SKIP_FRAMES + 1);
    localparam cap_state_t RESYNC = (SKIP_FRAMES > 0) ? SKIP : CAPTURE;

    cap_state_t       state, state_nxt;
    logic [WCW-1:0]   word_cnt, word_cnt_nxt;
    logic [SCW-1:0]   skip_cnt, skip_cnt_nxt;
    logic [FCW-1:0]   frame_cnt_nxt;
    logic             err_set;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             beat;
    logic             last_word;
    logic             tlast_bad;

    assign s_axis_tready = (state != IDLE);
    assign capturing     = (state == CAPTURE);
    assign full          = (state == FULL);

    assign beat      = s_axis_tvalid & s_axis_tready;
    assign last_word = (word_cnt == WCW'(FFT_LEN - 1));
    assign tlast_bad = (s_axis_tlast != last_word);

    // Frame base is derived from frame_cnt, so discarding a partial frame only
    // needs word_cnt cleared; the write address rewinds by itself.
    assign wr_addr = AW'(int'(frame_cnt) * FFT_LEN + int'(word_cnt));

    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        skip_cnt_nxt  = skip_cnt;
        frame_cnt_nxt = frame_cnt;
        err_set       = 1'b0;
        wr_en         = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = SYNC;
                end
            end

            SYNC: begin
                if (beat && s_axis_tlast) begin
                    state_nxt    = RESYNC;
                    word_cnt_nxt = '0;
                    skip_cnt_nxt = '0;
                end
            end

            SKIP: begin
                if (beat) begin
                    if (tlast_bad) begin
                        // An early tlast is itself a usable sync point; a missing one is not.
                        err_set      = 1'b1;
                        word_cnt_nxt = '0;
                        skip_cnt_nxt = '0;
                        state_nxt    = s_axis_tlast ? RESYNC : SYNC;
                    end else if (last_word) begin
                        word_cnt_nxt = '0;
                        if (skip_cnt == SCW'(SKIP_FRAMES - 1)) begin
                            skip_cnt_nxt = '0;
                            state_nxt    = CAPTURE;
                        end else begin
                            skip_cnt_nxt = skip_cnt + SCW'(1);
                        end
                    end else begin
                        word_cnt_nxt = word_cnt + WCW'(1);
                    end
                end
            end

            CAPTURE: begin
                if (beat) begin
                    if (tlast_bad) begin
                        err_set      = 1'b1;
                        word_cnt_nxt = '0;
                        skip_cnt_nxt = '0;
                        state_nxt    = s_axis_tlast ? RESYNC : SYNC;
                    end else begin
                        wr_en = 1'b1;
                        if (last_word) begin
                            word_cnt_nxt  = '0;
                            frame_cnt_nxt = frame_cnt + FCW'(1);
                            if (frame_cnt == FCW'(FRAMES - 1)) begin
                                state_nxt = FULL;
                            end
                        end else begin
                            word_cnt_nxt = word_cnt + WCW'(1);
                        end
                    end
                end
            end

            FULL: begin
                state_nxt = FULL;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_cnt  <= '0;
            skip_cnt  <= '0;
            frame_cnt <= '0;
            tlast_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            skip_cnt  <= skip_cnt_nxt;
            frame_cnt <= frame_cnt_nxt;
            if (err_set) begin
                tlast_err <= 1'b1;
            end
        end
    end

    capture_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture: ramp stream with tlast on word 20 mod 64,
// four captured frames after two skipped, plus error, back-pressure-free and reset cases.
module tb_axis_frame_capture;
    import alpaca_ospfb_utils_pkg::*;

    localparam int WIDTH   = 32;
    localparam int FFT_LEN = CAP_FFT_LEN;
    localparam int FRAMES  = 4;
    localparam int SKIP    = 2;
    localparam int DEPTH   = FRAMES * FFT_LEN;
    localparam int AW      = $clog2(DEPTH);
    localparam int FCW     = $clog2(FRAMES + 1);

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             capturing;
    logic [FCW-1:0]   frame_cnt;
    logic             tlast_err;

    int n_chk;
    int n_pass;
    int sbase;
    int sidx;
    int inject_i;
    int full_at;
    int ready_seen;
    bit rnd;

    axis_frame_capture #(
        .WIDTH       (WIDTH),
        .FFT_LEN     (FFT_LEN),
        .FRAMES      (FRAMES),
        .SKIP_FRAMES (SKIP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .full          (full),
        .capturing     (capturing),
        .frame_cnt     (frame_cnt),
        .tlast_err     (tlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        en            = 1'b0;
        rst           = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic arm();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Drive the ramp until sidx beats have been accepted or the cycle budget runs out.
    task automatic stream_to(input string tag, input int target, input int max_cycles, input bit must_reach);
        int  cyc;
        bit  v;
        bit  took;
        cyc = 0;
        while (sidx < target && cyc < max_cycles) begin
            @(negedge clk);
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid = v;
            s_axis_tdata  = WIDTH'(sbase + sidx);
            s_axis_tlast  = ((sidx % FFT_LEN) == 20) || (sidx == inject_i);
            took = v && s_axis_tready;
            @(posedge clk);
            #1;
            if (took) sidx++;
            if (s_axis_tready) ready_seen++;
            if (full && full_at < 0) full_at = sidx - 1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (must_reach) chk({tag, "_reach"}, sidx, target);
    endtask

    task automatic check_ram(input string tag, input int split, input int v0, input int v1);
        int          errs;
        logic [31:0] e;
        errs = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            rd_addr = AW'(k);
            @(posedge clk);
            #1;
            e = (k < split) ? 32'(sbase + v0 + k) : 32'(sbase + v1 + k - split);
            if (k == 0) chk({tag, "_ram0"}, rd_data, e);
            else if (k == DEPTH - 1) chk({tag, "_ramlast"}, rd_data, e);
            else if (rd_data !== e) errs++;
        end
        chk({tag, "_ram_errs"}, errs, 0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; en = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        rd_addr = '0;
        rnd = 1'b0; inject_i = -1; full_at = -1; ready_seen = 0;
        sbase = 0; sidx = 0;

        // Reset state and idle behaviour with a live stream and en low
        do_reset();
        chk("rst_full", full, 0);
        chk("rst_capturing", capturing, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_tlast_err", tlast_err, 0);
        chk("rst_tready", s_axis_tready, 0);
        stream_to("idle", 1000, 40, 1'b0);
        chk("idle_no_beats", sidx, 0);
        chk("idle_tready_seen", ready_seen, 0);
        chk("idle_full", full, 0);

        // Basic capture: first captured word is 149, last is 404
        sbase = 0; sidx = 0; full_at = -1;
        arm();
        stream_to("cap_mid", 200, 1000, 1'b1);
        chk("cap_mid_capturing", capturing, 1);
        chk("cap_mid_frame_cnt", frame_cnt, 0);
        chk("cap_mid_full", full, 0);
        stream_to("cap", 405, 1000, 1'b1);
        chk("cap_full_at", full_at, 404);
        chk("cap_full", full, 1);
        chk("cap_capturing", capturing, 0);
        chk("cap_frame_cnt", frame_cnt, FRAMES);
        chk("cap_tlast_err", tlast_err, 0);
        check_ram("cap", DEPTH, 149, 0);

        // Keep streaming while full: beats accepted, ram frozen
        stream_to("post", 505, 300, 1'b1);
        chk("post_tready", s_axis_tready, 1);
        chk("post_full", full, 1);
        check_ram("post", DEPTH, 149, 0);
        do_reset();
        chk("post_rst_full", full, 0);
        chk("post_rst_tready", s_axis_tready, 0);
        chk("post_rst_frame_cnt", frame_cnt, 0);
        ready_seen = 0;
        stream_to("post_idle", 10000, 40, 1'b0);
        chk("post_idle_ready", ready_seen, 0);
        check_ram("preload", DEPTH, 149, 0);

        // Random tvalid gaps must not change what is stored
        sbase = 32'h1000; sidx = 0; full_at = -1; rnd = 1'b1;
        arm();
        stream_to("rnd", 405, 4000, 1'b1);
        rnd = 1'b0;
        chk("rnd_full_at", full_at, 404);
        chk("rnd_frame_cnt", frame_cnt, FRAMES);
        check_ram("rnd", DEPTH, 149, 0);

        // Early tlast in captured frame 2; the stream's real tlast then resyncs again
        do_reset();
        sbase = 32'h2000; sidx = 0; full_at = -1; inject_i = 307;
        arm();
        stream_to("err_pre", 300, 1000, 1'b1);
        chk("err_pre_flag", tlast_err, 0);
        chk("err_pre_frame_cnt", frame_cnt, 2);
        stream_to("err_mid", 330, 200, 1'b1);
        chk("err_mid_flag", tlast_err, 1);
        chk("err_mid_capturing", capturing, 0);
        chk("err_mid_frame_cnt", frame_cnt, 2);
        stream_to("err", 597, 2000, 1'b1);
        inject_i = -1;
        chk("err_full_at", full_at, 596);
        chk("err_frame_cnt", frame_cnt, FRAMES);
        chk("err_flag_sticky", tlast_err, 1);
        check_ram("err", 128, 149, 469);

        // Reset in the middle of captured frame 1, re-arm, realign on next tlast
        do_reset();
        chk("rst2_tlast_err", tlast_err, 0);
        sbase = 32'h3000; sidx = 0; full_at = -1;
        arm();
        stream_to("mid", 230, 1000, 1'b1);
        chk("mid_capturing", capturing, 1);
        chk("mid_frame_cnt", frame_cnt, 1);
        do_reset();
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_capturing", capturing, 0);
        arm();
        stream_to("rearm", 661, 2000, 1'b1);
        chk("rearm_full_at", full_at, 660);
        chk("rearm_frame_cnt", frame_cnt, FRAMES);
        check_ram("rearm", DEPTH, 405, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
